// File: rtl/stopwatch_overlay_pkg.sv
// Shared definitions for the stopwatch overlay: VGA bus layout, glyph codes,
// BCD FSM states and the built-in digit font.
package stopwatch_overlay_pkg;

    // Default text box placement
    localparam int unsigned STOPWATCH_OVERLAY_X_POS = 16;
    localparam int unsigned STOPWATCH_OVERLAY_Y_POS = 8;

    // Glyph geometry and special codes (0-9 are the digits themselves)
    localparam int unsigned GLYPH_W     = 8;
    localparam int unsigned GLYPH_H     = 16;
    localparam logic [3:0]  GLYPH_COLON = 4'd10;
    localparam logic [3:0]  GLYPH_BLANK = 4'd11;

    // VGA bus field widths
    localparam int unsigned VGA_HCOUNT_BITS = 11;
    localparam int unsigned VGA_VCOUNT_BITS = 11;
    localparam int unsigned VGA_RGB_BITS    = 12;
    localparam int unsigned VGA_BUS_SIZE    = VGA_VCOUNT_BITS + VGA_HCOUNT_BITS + 4 + VGA_RGB_BITS;

    typedef struct packed {
        logic [VGA_VCOUNT_BITS-1:0] vcount;
        logic                       vsync;
        logic                       vblnk;
        logic [VGA_HCOUNT_BITS-1:0] hcount;
        logic                       hsync;
        logic                       hblnk;
        logic [VGA_RGB_BITS-1:0]    rgb;
    } vga_bus_t;

    typedef enum logic [1:0] {
        IDLE,
        CONV_MIN,
        CONV_SEC,
        COMMIT
    } bcd_state_t;

    // Saturate a stopwatch field to the displayable range 0..59
    function automatic logic [5:0] clamp59(input logic [5:0] v);
        return (v > 6'd59) ? 6'd59 : v;
    endfunction

    // Seven-segment map {a,b,c,d,e,f,g} for digits 0-9
    function automatic logic [6:0] digit_segments(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // One 8-pixel font row; bit 7 is the leftmost column. Digits are drawn as
    // seven-segment shapes: a=row 1, f/b=rows 2-6, g=row 7, e/c=rows 8-13, d=row 14.
    function automatic logic [7:0] font_row(input logic [3:0] code, input logic [3:0] row);
        logic [6:0] s;
        logic [7:0] r;
        r = '0;
        s = digit_segments(code);
        if (code == GLYPH_COLON) begin
            if (row == 4'd4 || row == 4'd5 || row == 4'd10 || row == 4'd11)
                r = 8'b0001_1000;
        end else if (code <= 4'd9) begin
            if (row == 4'd1)
                r = s[6] ? 8'b0111_1110 : 8'b0;
            else if (row >= 4'd2 && row <= 4'd6)
                r = (s[1] ? 8'b0100_0000 : 8'b0) | (s[5] ? 8'b0000_0010 : 8'b0);
            else if (row == 4'd7)
                r = s[0] ? 8'b0111_1110 : 8'b0;
            else if (row >= 4'd8 && row <= 4'd13)
                r = (s[2] ? 8'b0100_0000 : 8'b0) | (s[4] ? 8'b0000_0010 : 8'b0);
            else if (row == 4'd14)
                r = s[3] ? 8'b0111_1110 : 8'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_overlay_font_rom.sv
// 256x8 glyph ROM, address = {code, row}, registered read (1-cycle latency).
module digit_font_rom
    import stopwatch_overlay_pkg::*;
(
    input  logic       clk,
    input  logic [7:0] addr,
    output logic [7:0] data
);

    // Synchronous ROM read
    always_ff @(posedge clk)
        data <= font_row(addr[7:4], addr[3:0]);

endmodule

// File: rtl/stopwatch_overlay.sv
// Draws "MM:SS" onto the VGA bus. Time is converted to BCD once per frame
// during vertical blanking; glyph lookup uses a fixed 3-stage pipeline.
module stopwatch_overlay
    import stopwatch_overlay_pkg::*;
#(
    parameter int unsigned X_POS        = STOPWATCH_OVERLAY_X_POS,
    parameter int unsigned Y_POS        = STOPWATCH_OVERLAY_Y_POS,
    parameter int unsigned SCALE_LOG2   = 1,
    parameter logic [11:0] FG_COLOR     = 12'hFFF,
    parameter logic [11:0] BG_COLOR     = 12'h000,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [5:0]              minutes,
    input  logic [5:0]              seconds,
    input  logic [VGA_BUS_SIZE-1:0] vga_in,
    output logic [VGA_BUS_SIZE-1:0] vga_out,
    output logic                    busy
);

    localparam logic [11:0] BOX_X0     = 12'(X_POS);
    localparam logic [11:0] BOX_X1     = 12'(X_POS + (40 << SCALE_LOG2));
    localparam logic [11:0] BOX_Y0     = 12'(Y_POS);
    localparam logic [11:0] BOX_Y1     = 12'(Y_POS + (16 << SCALE_LOG2));
    localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);

    vga_bus_t   bus0, bus1, bus2, bus3, bus3_next;
    logic [11:0] hx, vy, hrel, vrel;
    logic        in_box0, in_box1, in_box2;
    logic [2:0]  slot1, col1, col2;
    logic [3:0]  row1;
    logic [3:0]  char_code;
    logic [7:0]  rom_data;
    logic        pix_on;

    logic        vblnk_q, frame_evt, start;
    bcd_state_t  state, state_next;
    logic [5:0]  work, sec_hold;
    logic [3:0]  min_tens, min_ones, sec_tens, sec_ones;
    logic [3:0]  disp_min_tens, disp_min_ones, disp_sec_tens, disp_sec_ones;
    logic [7:0]  blink_cnt;
    logic        colon_on;

    assign bus0    = vga_bus_t'(vga_in);
    assign vga_out = bus3;

    // Box hit test and glyph coordinates for the incoming pixel
    always_comb begin
        hx      = {1'b0, bus0.hcount};
        vy      = {1'b0, bus0.vcount};
        hrel    = hx - BOX_X0;
        vrel    = vy - BOX_Y0;
        in_box0 = (hx >= BOX_X0) && (hx < BOX_X1) && (vy >= BOX_Y0) && (vy < BOX_Y1)
                  && !bus0.hblnk && !bus0.vblnk;
    end

    // Character code for the slot currently in stage 1
    always_comb begin
        char_code = GLYPH_BLANK;
        case (slot1)
            3'd0: char_code = disp_min_tens;
            3'd1: char_code = disp_min_ones;
            3'd2: char_code = colon_on ? GLYPH_COLON : GLYPH_BLANK;
            3'd3: char_code = disp_sec_tens;
            3'd4: char_code = disp_sec_ones;
            default: char_code = GLYPH_BLANK;
        endcase
    end

    digit_font_rom u_font (
        .clk  (clk),
        .addr ({char_code, row1}),
        .data (rom_data)
    );

    // Final colour selection, aligned with the ROM output
    always_comb begin
        bus3_next = bus2;
        pix_on    = rom_data[3'd7 - col2];
        if (in_box2 && enable)
            bus3_next.rgb = pix_on ? FG_COLOR : BG_COLOR;
    end

    // Three-stage pixel pipeline; every bus field is delayed together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus1    <= '0;
            in_box1 <= 1'b0;
            slot1   <= '0;
            col1    <= '0;
            row1    <= '0;
            bus2    <= '0;
            in_box2 <= 1'b0;
            col2    <= '0;
            bus3    <= '0;
        end else begin
            bus1    <= bus0;
            in_box1 <= in_box0;
            slot1   <= 3'(hrel >> (3 + SCALE_LOG2));
            col1    <= 3'(hrel >> SCALE_LOG2);
            row1    <= 4'(vrel >> SCALE_LOG2);
            bus2    <= bus1;
            in_box2 <= in_box1;
            col2    <= col1;
            bus3    <= bus3_next;
        end
    end

    assign frame_evt = bus0.vblnk && !vblnk_q;

    // Previous vblnk for frame-start edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vblnk_q <= 1'b0;
        else
            vblnk_q <= bus0.vblnk;
    end

    // BCD FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // BCD FSM next state and busy flag; frame events while converting are dropped
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (frame_evt && enable) begin
                    start      = 1'b1;
                    state_next = CONV_MIN;
                end
            end
            CONV_MIN: begin
                busy = 1'b1;
                if (work < 6'd10)
                    state_next = CONV_SEC;
            end
            CONV_SEC: begin
                busy = 1'b1;
                if (work < 6'd10)
                    state_next = COMMIT;
            end
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Repeated-subtraction BCD datapath and displayed digit registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work          <= '0;
            sec_hold      <= '0;
            min_tens      <= '0;
            min_ones      <= '0;
            sec_tens      <= '0;
            sec_ones      <= '0;
            disp_min_tens <= '0;
            disp_min_ones <= '0;
            disp_sec_tens <= '0;
            disp_sec_ones <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work     <= clamp59(minutes);
                        sec_hold <= clamp59(seconds);
                        min_tens <= '0;
                        sec_tens <= '0;
                    end
                end
                CONV_MIN: begin
                    if (work >= 6'd10) begin
                        work     <= work - 6'd10;
                        min_tens <= min_tens + 4'd1;
                    end else begin
                        min_ones <= work[3:0];
                        work     <= sec_hold;
                    end
                end
                CONV_SEC: begin
                    if (work >= 6'd10) begin
                        work     <= work - 6'd10;
                        sec_tens <= sec_tens + 4'd1;
                    end else begin
                        sec_ones <= work[3:0];
                    end
                end
                COMMIT: begin
                    disp_min_tens <= min_tens;
                    disp_min_ones <= min_ones;
                    disp_sec_tens <= sec_tens;
                    disp_sec_ones <= sec_ones;
                end
                default: ;
            endcase
        end
    end

    // Colon blink: toggles every BLINK_FRAMES enabled frame events
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            colon_on  <= 1'b1;
        end else if (frame_evt && enable) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                colon_on  <= !colon_on;
            end else begin
                blink_cnt <= blink_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_overlay.sv
// Directed bench for stopwatch_overlay (defaults except BLINK_FRAMES=2).
module tb_stopwatch_overlay;
    import stopwatch_overlay_pkg::*;

    localparam logic [11:0] IN_RGB = 12'h5A3;
    localparam logic [11:0] FG     = 12'hFFF;
    localparam logic [11:0] BG     = 12'h000;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [5:0] minutes, seconds;
    vga_bus_t   vin, vout;
    logic       busy;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    stopwatch_overlay #(
        .BLINK_FRAMES (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .minutes (minutes),
        .seconds (seconds),
        .vga_in  (vin),
        .vga_out (vout),
        .busy    (busy)
    );

    function automatic vga_bus_t mk(input int h, input int v, input logic hb, input logic vb,
                                    input logic [11:0] rgb);
        vga_bus_t b;
        b        = '0;
        b.hcount = 11'(h);
        b.vcount = 11'(v);
        b.hblnk  = hb;
        b.vblnk  = vb;
        b.rgb    = rgb;
        return b;
    endfunction

    task automatic px_raw(input int h, input int v, input logic hb, output logic [11:0] rgb);
        @(negedge clk);
        vin = mk(h, v, hb, 1'b0, IN_RGB);
        repeat (3) @(negedge clk);
        rgb = vout.rgb;
    endtask

    task automatic px(input int slot, input int col, input int row, output logic [11:0] rgb);
        px_raw(16 + slot * 16 + col * 2, 8 + row * 2, 1'b0, rgb);
    endtask

    // One vblank rising edge, then 20 blanking cycles; counts cycles with busy high
    task automatic frame(output int bc);
        bc = 0;
        @(negedge clk);
        vin = mk(200, 600, 1'b0, 1'b0, 12'h123);
        @(negedge clk);
        vin = mk(200, 600, 1'b1, 1'b1, 12'h123);
        repeat (20) begin
            @(negedge clk);
            if (busy) bc++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        vin = mk(300, 700, 1'b0, 1'b0, 12'h000);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        vga_bus_t b;
        logic [11:0] got, want;
        int bc;
        int pr [6][4];
        enable  = 1'b1;
        minutes = 6'd0;
        seconds = 6'd0;
        rst     = 1'b1;
        b       = mk(300, 200, 1'b0, 1'b0, 12'hABC);
        vin     = b;
        repeat (2) @(negedge clk);
        tests++;
        if (vout !== '0) begin failed++; $display("FAIL reset_vga_out: got %h expected 0", vout); end
        tests++;
        if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            tests++;
            if (vout !== ((i < 3) ? vga_bus_t'('0) : b)) begin
                failed++;
                $display("FAIL release_latency cycle %0d: got %h expected %h", i, vout,
                         (i < 3) ? vga_bus_t'('0) : b);
            end
        end
        frame(bc);
        tests++;
        if (bc !== 2) begin failed++; $display("FAIL busy_0000: got %0d cycles expected 2", bc); end
        pr = '{'{0, 0, 0, 0}, '{0, 3, 1, 1}, '{0, 3, 7, 0}, '{4, 1, 10, 1}, '{2, 3, 4, 1}, '{2, 3, 7, 0}};
        for (int i = 0; i < 6; i++) begin
            px(pr[i][0], pr[i][1], pr[i][2], got);
            want = (pr[i][3] != 0) ? FG : BG;
            tests++;
            if (got !== want) begin failed++; $display("FAIL digits_0000 probe %0d: got %h expected %h", i, got, want); end
        end
    endtask

    task automatic test_passthrough();
        vga_bus_t sent [40];
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k >= 3) begin
                tests++;
                if (vout !== sent[k-3]) begin
                    failed++;
                    $display("FAIL passthrough step %0d: got %h expected %h", k, vout, sent[k-3]);
                end
            end
            sent[k]        = vga_bus_t'($urandom);
            sent[k].vcount = 11'(100 + $urandom_range(0, 900));
            sent[k].hcount = 11'($urandom_range(0, 1343));
            sent[k].vblnk  = 1'b0;
            sent[k].rgb    = 12'($urandom);
            vin            = sent[k];
        end
    endtask

    task automatic test_bcd_1247();
        logic [11:0] got, want;
        int bc;
        int pr [9][4];
        minutes = 6'd12;
        seconds = 6'd47;
        frame(bc);
        tests++;
        if (bc !== 7) begin failed++; $display("FAIL busy_1247: got %0d cycles expected 7", bc); end
        pr = '{'{0, 0, 0, 0}, '{0, 3, 1, 0}, '{0, 6, 3, 1}, '{1, 3, 7, 1}, '{1, 6, 10, 0},
               '{3, 1, 3, 1}, '{3, 3, 1, 0}, '{4, 6, 10, 1}, '{4, 3, 7, 0}};
        for (int i = 0; i < 9; i++) begin
            px(pr[i][0], pr[i][1], pr[i][2], got);
            want = (pr[i][3] != 0) ? FG : BG;
            tests++;
            if (got !== want) begin failed++; $display("FAIL digits_1247 probe %0d: got %h expected %h", i, got, want); end
        end
    endtask

    task automatic test_clamp();
        logic [11:0] got, want;
        int bc;
        int pr [7][4];
        minutes = 6'd63;
        seconds = 6'd60;
        frame(bc);
        tests++;
        if (bc !== 12) begin failed++; $display("FAIL busy_clamp: got %0d cycles expected 12", bc); end
        pr = '{'{0, 6, 3, 0}, '{0, 1, 3, 1}, '{1, 1, 10, 0}, '{1, 3, 7, 1}, '{3, 6, 3, 0},
               '{4, 1, 10, 0}, '{4, 3, 14, 1}};
        for (int i = 0; i < 7; i++) begin
            px(pr[i][0], pr[i][1], pr[i][2], got);
            want = (pr[i][3] != 0) ? FG : BG;
            tests++;
            if (got !== want) begin failed++; $display("FAIL digits_5959 probe %0d: got %h expected %h", i, got, want); end
        end
    endtask

    task automatic test_mid_frame();
        logic [11:0] got;
        int bc;
        minutes = 6'd0;
        seconds = 6'd5;
        frame(bc);
        px(4, 1, 10, got);
        tests++;
        if (got !== BG) begin failed++; $display("FAIL sec5_e_segment: got %h expected %h", got, BG); end
        seconds = 6'd6;
        px(4, 1, 10, got);
        tests++;
        if (got !== BG) begin failed++; $display("FAIL midframe_still5: got %h expected %h", got, BG); end
        tests++;
        if (busy !== 1'b0) begin failed++; $display("FAIL midframe_busy: got %b expected 0", busy); end
        frame(bc);
        tests++;
        if (bc !== 2) begin failed++; $display("FAIL busy_0006: got %0d cycles expected 2", bc); end
        px(4, 1, 10, got);
        tests++;
        if (got !== FG) begin failed++; $display("FAIL nextframe_6: got %h expected %h", got, FG); end
    endtask

    task automatic test_box_edges();
        logic [11:0] got;
        int pr [8][4];
        logic [11:0] want [8];
        // h, v, hblnk, index into want; display currently reads 00:06
        pr   = '{'{15, 10, 0, 0}, '{16, 8, 0, 0}, '{95, 39, 0, 0}, '{96, 20, 0, 0},
                 '{40, 7, 0, 0}, '{40, 40, 0, 0}, '{22, 10, 1, 0}, '{22, 10, 0, 0}};
        want = '{IN_RGB, BG, BG, IN_RGB, IN_RGB, IN_RGB, IN_RGB, FG};
        for (int i = 0; i < 8; i++) begin
            px_raw(pr[i][0], pr[i][1], pr[i][2] != 0, got);
            tests++;
            if (got !== want[i]) begin failed++; $display("FAIL box_edge probe %0d: got %h expected %h", i, got, want[i]); end
        end
    endtask

    task automatic test_blink();
        logic [11:0] got, want;
        int bc;
        logic vis [8];
        vis = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        enable  = 1'b1;
        minutes = 6'd12;
        seconds = 6'd47;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) frame(bc);
            px(2, 3, 4, got);
            want = vis[k] ? FG : BG;
            tests++;
            if (got !== want) begin failed++; $display("FAIL blink frame %0d: got %h expected %h", k, got, want); end
        end
        enable = 1'b0;
        px(0, 6, 3, got);
        tests++;
        if (got !== IN_RGB) begin failed++; $display("FAIL disabled_digit: got %h expected %h", got, IN_RGB); end
        px(2, 3, 4, got);
        tests++;
        if (got !== IN_RGB) begin failed++; $display("FAIL disabled_colon: got %h expected %h", got, IN_RGB); end
        minutes = 6'd34;
        frame(bc);
        tests++;
        if (bc !== 0) begin failed++; $display("FAIL disabled_busy: got %0d cycles expected 0", bc); end
        enable = 1'b1;
        px(0, 3, 1, got);
        tests++;
        if (got !== BG) begin failed++; $display("FAIL frozen_digit: got %h expected %h", got, BG); end
        px(2, 3, 4, got);
        tests++;
        if (got !== BG) begin failed++; $display("FAIL frozen_colon: got %h expected %h", got, BG); end
        frame(bc);
        tests++;
        if (bc !== 9) begin failed++; $display("FAIL busy_3447: got %0d cycles expected 9", bc); end
        px(0, 3, 1, got);
        tests++;
        if (got !== FG) begin failed++; $display("FAIL resumed_digit: got %h expected %h", got, FG); end
        px(2, 3, 4, got);
        tests++;
        if (got !== FG) begin failed++; $display("FAIL resumed_colon: got %h expected %h", got, FG); end
    endtask

    task automatic test_mid_reset();
        logic [11:0] got, want;
        int bc;
        int pr [6][4];
        enable  = 1'b1;
        minutes = 6'd12;
        seconds = 6'd47;
        @(negedge clk);
        vin = mk(200, 600, 1'b0, 1'b0, 12'h123);
        @(negedge clk);
        vin = mk(200, 600, 1'b1, 1'b1, 12'h123);
        repeat (3) @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin failed++; $display("FAIL conv_sec_busy: got %b expected 1", busy); end
        rst = 1'b1;
        #1;
        tests++;
        if (busy !== 1'b0) begin failed++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        tests++;
        if (vout !== '0) begin failed++; $display("FAIL midreset_vga_out: got %h expected 0", vout); end
        @(negedge clk);
        vin = mk(200, 600, 1'b0, 1'b0, 12'h123);
        @(negedge clk);
        rst     = 1'b0;
        minutes = 6'd7;
        seconds = 6'd3;
        px(1, 3, 7, got);
        tests++;
        if (got !== BG) begin failed++; $display("FAIL midreset_digits_cleared: got %h expected %h", got, BG); end
        frame(bc);
        tests++;
        if (bc !== 2) begin failed++; $display("FAIL busy_0703: got %0d cycles expected 2", bc); end
        pr = '{'{0, 3, 1, 1}, '{1, 3, 7, 0}, '{1, 6, 3, 1}, '{3, 3, 7, 0}, '{4, 1, 10, 0}, '{4, 3, 1, 1}};
        for (int i = 0; i < 6; i++) begin
            px(pr[i][0], pr[i][1], pr[i][2], got);
            want = (pr[i][3] != 0) ? FG : BG;
            tests++;
            if (got !== want) begin failed++; $display("FAIL digits_0703 probe %0d: got %h expected %h", i, got, want); end
        end
    endtask

    initial begin
        rst     = 1'b1;
        enable  = 1'b0;
        minutes = '0;
        seconds = '0;
        vin     = '0;
        test_reset();
        test_passthrough();
        test_bcd_1247();
        test_clamp();
        test_mid_frame();
        test_box_edges();
        test_blink();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within 200000 time units");
        $fatal(1);
    end

endmodule
